uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit serializer for the APB serial peripheral; sits directly downstream of the TX FIFO register file.
- Pops bytes from the FIFO one at a time and shifts each out as an asynchronous serial frame: start bit, DATA_WIDTH data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from a runtime clock divisor supplied by the APB register block.

Parameters:
- DATA_WIDTH, 8, data bits per frame; equals FIFO regWidth.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- tx_enable  input  1  allows a new frame to start; sampled only in IDLE and on the last stop-bit cycle.
- baud_div  input  DIV_WIDTH  clocks per bit; values 0 and 1 are treated as 2.
- parity_en  input  1  1 = append a parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- stop2  input  1  1 = two stop bits, 0 = one stop bit.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_rdata  input  DATA_WIDTH  FIFO head data, combinationally valid whenever fifo_empty=0.
- fifo_pop  output  1  one-cycle pulse that advances the FIFO read pointer.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  high from the cycle after a pop until the frame's last stop-bit cycle completes.
- tx_done  output  1  one-cycle pulse in the final cycle of each frame.

Behaviour:
- Reset values (asynchronous, immediate on n_rst low): tx_serial=1, fifo_pop=0, tx_busy=0, tx_done=0, state=IDLE, bit and baud counters 0.
- Load condition: tx_enable=1 AND fifo_empty=0.
- Pop cycle:
  - When the load condition holds in IDLE, fifo_pop=1 for exactly that cycle.
  - In the same cycle, fifo_rdata is captured into the shift register and baud_div (clamped), parity_en, parity_odd and stop2 are latched.
  - Config input changes mid-frame have no effect until the next pop.
- States: IDLE, START, DATA, PARITY, STOP.
  - START begins the cycle after the pop, so tx_serial falls 1 cycle after fifo_pop.
  - Each state holds tx_serial constant for exactly D clocks, D = latched clamped divisor.
  - A baud counter runs 0..D-1; the state or bit advances when count = D-1.
- START: tx_serial=0 for D clocks, then go to DATA.
- DATA: shift-register bit 0 is driven first; shift right each bit period. After DATA_WIDTH bits, go to PARITY if parity_en, else STOP.
- PARITY:
  - tx_serial = XOR of the latched data bits, inverted when parity_odd.
  - Even parity makes the total count of ones (data + parity) even.
  - Lasts D clocks, then go to STOP.
- STOP: tx_serial=1 for D clocks (stop2=0) or 2·D clocks (stop2=1).
- Final cycle of STOP:
  - tx_done=1.
  - If the load condition holds, fifo_pop=1 in that same cycle and the next cycle is START (back-to-back, no idle gap). tx_busy stays 1 through the transition.
  - Otherwise go to IDLE; tx_busy=0 from the next cycle.
- tx_enable falling mid-frame: the current frame completes; no further pop occurs.
- fifo_empty rising mid-frame: no effect on the current frame.
- fifo_pop is never asserted while fifo_empty=1 and never more than once per frame.
- Frame length in clocks: D·(1 + DATA_WIDTH + parity_en + 1 + stop2).
- Reset mid-frame: line returns high immediately, the frame is abandoned, and no pop is issued. The FIFO pointer state is the FIFO's concern.

Test Plan:
- baud_div=4, 8N1, FIFO holds 0x55:
  - One fifo_pop.
  - tx_serial = 0 then 1,0,1,0,1,0,1,0 then 1, each bit 4 clocks.
  - tx_done pulses at clock 40 after the pop; tx_busy low afterwards.
- baud_div=3, parity_en=1: data 0x07 with parity_odd=0 gives parity bit 1; data 0x07 with parity_odd=1 gives parity bit 0. Frame length is 33 clocks.
- FIFO holds 0xA5 then 0x3C, baud_div=2, stop2=1:
  - Second fifo_pop coincides with the first tx_done.
  - Second start bit immediately follows the 4-clock stop period; no idle cycle between frames.
- fifo_empty=1 with tx_enable=1 for 100 clocks: fifo_pop never asserts; tx_serial=1; tx_busy=0.
- baud_div=0 and baud_div=1: each bit lasts 2 clocks; an 8N1 frame is 20 clocks.
- Assert n_rst low during DATA bit 3 of 0x00: tx_serial=1 in the same cycle, no fifo_pop, and after release IDLE resumes normal operation.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read port: empty flag and head data from the FIFO, pop pulse back to it.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_pop;

  modport master (output fifo_empty, output fifo_rdata, input fifo_pop);
  modport slave  (input fifo_empty, input fifo_rdata, output fifo_pop);
endinterface

// File: rtl/uart_tx_engine.sv
// UART serializer: pops one FIFO byte per frame; line falls 1 clk after the pop and a frame lasts D*(bits) clks.
// Waits on fifo_empty/tx_enable; a back-to-back pop lands in the last stop-bit cycle, so there is no idle gap.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_enable,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  uart_tx_engine_if.slave      fifo,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  div_clamp;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  load;
  logic                  tick;
  logic                  frame_end;
  logic                  pop;

  assign div_clamp = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign tick      = (baud_cnt == (div_q - DIV_WIDTH'(1)));
  // In STOP the bit counter indexes stop bits: 0 only, or 0 then 1.
  assign frame_end = (state == STOP) && tick && (bit_cnt[0] == stop2_q);
  // Gating with n_rst keeps a pop from leaking out while reset is held.
  assign load      = tx_enable & ~fifo.fifo_empty & n_rst;
  assign pop       = load & ((state == IDLE) | frame_end);

  assign fifo.fifo_pop = pop;
  assign tx_done       = frame_end;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      div_q     <= DIV_WIDTH'(2);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else if (pop) begin
      state     <= START;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= fifo.fifo_rdata;
      div_q     <= div_clamp;
      par_en_q  <= parity_en;
      par_bit_q <= (^fifo.fifo_rdata) ^ parity_odd;
      stop2_q   <= stop2;
      tx_serial <= 1'b0;
      tx_busy   <= 1'b1;
    end else if (state != IDLE) begin
      if (!tick) begin
        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state     <= DATA;
            tx_serial <= shreg[0];
          end
          DATA: begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state     <= PARITY;
                tx_serial <= par_bit_q;
              end else begin
                state     <= STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + BW'(1);
              shreg     <= shreg >> 1;
              tx_serial <= shreg[1];
            end
          end
          PARITY: begin
            state     <= STOP;
            tx_serial <= 1'b1;
          end
          STOP: begin
            if (bit_cnt[0] == stop2_q) begin
              state   <= IDLE;
              bit_cnt <= '0;
              tx_busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: FIFO model plus a frame model built as a list of line levels, one per clock.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        tx_enable;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;

  logic [7:0]  fq[$];
  logic        pop_edge;
  int          errors = 0;
  int          checks = 0;

  uart_tx_engine_if #(.DATA_WIDTH(8)) fifo_bus ();

  uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_enable  (tx_enable),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo       (fifo_bus),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    fifo_bus.fifo_empty = (fq.size() == 0);
    fifo_bus.fifo_rdata = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    refresh();
  endtask

  // FIFO read pointer advances on the edge where the pop was seen.
  always begin
    @(posedge clk);
    pop_edge = fifo_bus.fifo_pop;
    #1;
    if (pop_edge === 1'b1 && fq.size() != 0) void'(fq.pop_front());
    refresh();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    #1;
    while (fifo_bus.fifo_pop !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_pop_seen"}, 32'(fifo_bus.fifo_pop), 32'd1);
  endtask

  // Call in the pop cycle; walks every clock of the frame against the level list.
  task automatic check_frame(input string tag, input logic [7:0] d, input int div,
                             input bit pe, input bit po, input bit s2,
                             input bit exp_pop_end, input int mid);
    logic lv[$];
    int   dd;
    int   ones;
    int   len;
    dd   = (div < 2) ? 2 : div;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    for (int c = 0; c < dd; c++) lv.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < dd; c++) lv.push_back(d[i]);
    if (pe)
      for (int c = 0; c < dd; c++) lv.push_back(1'((ones % 2) ^ int'(po)));
    for (int c = 0; c < dd * (1 + int'(s2)); c++) lv.push_back(1'b1);
    len = lv.size();
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == len / 2) begin
        if (mid == 1) begin
          baud_div   = 16'($urandom);
          parity_en  = 1'($urandom_range(0, 1));
          parity_odd = 1'($urandom_range(0, 1));
          stop2      = 1'($urandom_range(0, 1));
        end else if (mid == 2) begin
          tx_enable = 1'b0;
        end
      end
      chk({tag, "_serial"}, 32'(tx_serial), 32'(lv[k-1]));
      chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
      chk({tag, "_done"}, 32'(tx_done), 32'(k == len));
      chk({tag, "_pop"}, 32'(fifo_bus.fifo_pop), (k == len) ? 32'(exp_pop_end) : 32'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    step();
    chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_idle_serial"}, 32'(tx_serial), 32'd1);
    chk({tag, "_idle_done"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         dv;
    bit         pe, po, s2;

    n_rst      = 1'b0;
    tx_enable  = 1'b0;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    refresh();
    step();
    step();
    chk("rst_serial", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    push(8'h55);
    tx_enable = 1'b1;
    #1;
    chk("rst_pop_gated", 32'(fifo_bus.fifo_pop), 32'd0);
    step();
    chk("rst_pop_held", 32'(fifo_bus.fifo_pop), 32'd0);

    // 8N1, divisor 4, 0x55
    n_rst = 1'b1;
    wait_pop("t55");
    check_frame("t55", 8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("t55");

    // Parity even then odd on 0x07, config scrambled mid-frame
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
    push(8'h07);
    wait_pop("par_even");
    check_frame("par_even", 8'h07, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check_idle("par_even");
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b0;
    push(8'h07);
    wait_pop("par_odd");
    check_frame("par_odd", 8'h07, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    check_idle("par_odd");

    // Back-to-back frames, two stop bits
    baud_div = 16'd2; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    push(8'hA5);
    push(8'h3C);
    wait_pop("b2b_a");
    check_frame("b2b_a", 8'hA5, 2, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check_frame("b2b_b", 8'h3C, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_idle("b2b");

    // Empty FIFO with enable held
    for (int i = 0; i < 100; i++) begin
      step();
      chk("empty_pop", 32'(fifo_bus.fifo_pop), 32'd0);
      chk("empty_serial", 32'(tx_serial), 32'd1);
      chk("empty_busy", 32'(tx_busy), 32'd0);
    end

    // Divisor clamp at 0 and 1
    stop2 = 1'b0; baud_div = 16'd0;
    push(8'h5A);
    wait_pop("div0");
    check_frame("div0", 8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("div0");
    baud_div = 16'd1;
    push(8'hC3);
    wait_pop("div1");
    check_frame("div1", 8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("div1");

    // Enable dropped mid-frame: frame completes, second byte stays queued
    baud_div = 16'd2;
    push(8'h11);
    push(8'h22);
    wait_pop("endrop");
    check_frame("endrop", 8'h11, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("endrop_nopop", 32'(fifo_bus.fifo_pop), 32'd0);
      chk("endrop_busy", 32'(tx_busy), 32'd0);
    end
    tx_enable = 1'b1;
    wait_pop("endrop2");
    check_frame("endrop2", 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("endrop2");

    // Reset during data bit 3 of 0x00, another byte waiting
    baud_div = 16'd4;
    push(8'h00);
    push(8'h99);
    wait_pop("rstmid");
    for (int k = 1; k <= 18; k++) step();
    chk("rstmid_bit3", 32'(tx_serial), 32'd0);
    n_rst = 1'b0;
    #1;
    chk("rstmid_serial", 32'(tx_serial), 32'd1);
    chk("rstmid_pop", 32'(fifo_bus.fifo_pop), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rstmid_hold_pop", 32'(fifo_bus.fifo_pop), 32'd0);
      chk("rstmid_hold_busy", 32'(tx_busy), 32'd0);
    end
    n_rst = 1'b1;
    wait_pop("rstmid_after");
    check_frame("rstmid_after", 8'h99, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_idle("rstmid_after");

    // Randomized frames
    for (int r = 0; r < 25; r++) begin
      d  = 8'($urandom);
      dv = int'($urandom_range(0, 5));
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      baud_div = 16'(dv); parity_en = pe; parity_odd = po; stop2 = s2;
      push(d);
      wait_pop("rnd");
      check_frame("rnd", d, dv, pe, po, s2, 1'b0, int'($urandom_range(0, 1)));
      check_idle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
